boot_loader: RTL and testbench

- Sits between an external byte stream (UART receiver or bench) and the rw_ram / cpu pair.
- Holds the multicycle MIPS cpu in reset while it receives a framed program image, byte by byte.
- Writes the image as 32-bit words into RAM starting at the text base, then verifies a checksum.
- On success it releases the cpu and hands the RAM port over to it. On failure it keeps the cpu in reset.

---
 rtl/boot_loader.sv | 197 +++++++++++++++++++
 tb/tb_boot_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: receives a framed program image over a byte stream, writes it
// into RAM as 32-bit words, verifies an XOR checksum, then releases the cpu
// and hands the RAM port over to it.

module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_w_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_q, words_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] xor_q, xor_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        last_byte;
  logic [31:0] word_w;
  logic [15:0] words_inc;

  // The loader only takes bytes while it is collecting a field
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_HDR, S_DATA, S_CHK: rx_ready = 1'b1;
      default:              rx_ready = 1'b0;
    endcase
  end

  assign accept    = clk_en & rx_valid & rx_ready;
  assign word_w    = {shift_q[23:0], rx_data};
  assign last_byte = accept & (byte_idx_q == 2'd3);
  assign words_inc = words_q + 16'd1;

  // Next-state logic: every register holds unless an enabled edge advances it
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    count_d    = count_q;
    words_d    = words_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    data_d     = data_q;
    xor_d      = xor_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = word_w;
    end

    case (state_q)
      S_HDR: begin
        if (last_byte) begin
          if (word_w == 32'd0) begin
            state_d = S_CHK;
          end else if (word_w > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            count_d = word_w[15:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (last_byte) begin
          data_d  = word_w;
          xor_d   = xor_q ^ word_w;
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (clk_en) begin
          wr_en_d = 1'b0;
          addr_d  = addr_q + 32'd4;
          words_d = words_inc;
          if (words_inc < count_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (last_byte) begin
          if (word_w == xor_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      S_DONE, S_ERR: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // State register; reset returns the loader to waiting for a header
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      count_q    <= 16'd0;
      words_q    <= 16'd0;
      wr_en_q    <= 1'b0;
      addr_q     <= BASE_ADDR;
      data_q     <= 32'd0;
      xor_q      <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      words_q    <= words_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      xor_q      <= xor_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // RAM port belongs to the cpu only once the image is verified
  always_comb begin
    mem_wr_en  = wr_en_q;
    mem_addr   = addr_q;
    mem_w_data = data_q;
    if (state_q == S_DONE) begin
      mem_wr_en  = cpu_wr_en;
      mem_addr   = cpu_mem_addr;
      mem_w_data = cpu_w_data;
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives framed images into boot_loader, predicts RAM writes
// and final status from the frame contents, and checks them via a scoreboard.

module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int MAXW = 1024;

  logic        clk_100M = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cpu_wr_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_w_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int testsRun = 0;
  int testsFailed = 0;

  logic [63:0] expQ[$];
  logic [31:0] ram[logic [31:0]];
  logic [31:0] frameWords[0:15];
  int  writesSeen = 0;
  bit  monitorOn = 1'b1;
  bit  toggleMode = 1'b0;
  logic phase = 1'b0;

  boot_loader dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_wr_en(cpu_wr_en), .cpu_mem_addr(cpu_mem_addr), .cpu_w_data(cpu_w_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .cpu_rst(cpu_rst), .done(done), .err(err), .words_loaded(words_loaded)
  );

  // 100 MHz clock
  always #5 clk_100M = ~clk_100M;

  // Clock enable is either always on or alternates every cycle
  always @(posedge clk_100M) phase <= ~phase;
  assign clk_en = !toggleMode || phase;

  // Watchdog so the run always ends
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every enabled-edge write from the loader is popped against the scoreboard
  always @(negedge clk_100M) begin
    if (rst_n && monitorOn && clk_en && mem_wr_en) begin
      logic [63:0] e;
      writesSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", mem_addr, 32'hxxxx_xxxx);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr", mem_addr, e[63:32]);
        checkOutput("write_data", mem_w_data, e[31:0]);
      end
      ram[mem_addr] = mem_w_data;
    end
  end

  // Offer one byte and wait until the loader takes it on an enabled edge
  task automatic applyStimulus(input logic [7:0] b);
    int  cyc = 0;
    bit  acc = 1'b0;
    if (!toggleMode) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk_100M); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && cyc < 64) begin
      @(negedge clk_100M);
      acc = rx_ready && clk_en;
      @(posedge clk_100M); #1;
      cyc++;
    end
    if (!toggleMode) rx_valid = 1'b0;
    if (!acc) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  // Asynchronous reset in mid-cycle; outputs must return at once
  task automatic applyReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst_mem_addr", mem_addr, BASE);
    checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    expQ.delete();
    rx_valid = 1'b0;
    repeat (2) @(posedge clk_100M);
    #1 rst_n = 1'b1;
    writesSeen = 0;
  endtask

  // Reference model: a frame of n words writes them in order from BASE,
  // and succeeds only if the checksum equals the XOR of the words.
  task automatic runFrame(input int n, input logic [31:0] corruptMask);
    logic [31:0] x = 32'd0;
    bit expOk;
    writesSeen = 0;
    for (int i = 0; i < n && i < 16; i++) x ^= frameWords[i];
    sendWord(32'(n));
    if (n > MAXW) begin
      checkOutput("hdr_err", 32'(err), 32'd1);
      checkOutput("hdr_cpu_rst", 32'(cpu_rst), 32'd1);
      checkOutput("hdr_done", 32'(done), 32'd0);
      checkOutput("hdr_rx_ready", 32'(rx_ready), 32'd0);
      repeat (4) @(posedge clk_100M);
      #1 checkOutput("hdr_writes", 32'(writesSeen), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) expQ.push_back({BASE + 32'(4 * i), frameWords[i]});
    for (int i = 0; i < n; i++) sendWord(frameWords[i]);
    sendWord(x ^ corruptMask);
    expOk = (corruptMask == 32'd0);
    checkOutput("end_done", 32'(done), 32'(expOk));
    checkOutput("end_err", 32'(err), 32'(!expOk));
    checkOutput("end_cpu_rst", 32'(cpu_rst), 32'(!expOk));
    checkOutput("end_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("end_words_loaded", 32'(words_loaded), 32'(n));
    checkOutput("end_writes", 32'(writesSeen), 32'(n));
    checkOutput("end_pending", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a = BASE + 32'(4 * i);
      checkOutput("ram_word", ram.exists(a) ? ram[a] : 32'hxxxx_xxxx, frameWords[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    cpu_wr_en = 1'b0;
    cpu_mem_addr = 32'd0;
    cpu_w_data = 32'd0;
    @(posedge clk_100M); #1;
    rst_n = 1'b1;
    @(posedge clk_100M); #1;
    applyReset();

    // Two-word program, correct checksum
    frameWords[0] = 32'h2008_0005;
    frameWords[1] = 32'h2009_0007;
    runFrame(2, 32'd0);

    // Bytes offered after DONE are ignored
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) @(posedge clk_100M);
    #1 rx_valid = 1'b0;
    checkOutput("done_hold", 32'(done), 32'd1);
    checkOutput("done_words_hold", 32'(words_loaded), 32'd2);

    // Same program with checksum 0x00010003
    applyReset();
    runFrame(2, 32'h0000_0001);

    // Oversized header
    applyReset();
    runFrame(1025, 32'd0);

    // Empty image, then the cpu owns the RAM port
    applyReset();
    runFrame(0, 32'd0);
    monitorOn = 1'b0;
    cpu_wr_en = 1'b1; cpu_mem_addr = 32'h10; cpu_w_data = 32'hDEAD_BEEF;
    #1;
    checkOutput("mux_wr_en", 32'(mem_wr_en), 32'd1);
    checkOutput("mux_addr", mem_addr, 32'h10);
    checkOutput("mux_data", mem_w_data, 32'hDEAD_BEEF);
    cpu_wr_en = 1'b0; cpu_mem_addr = 32'd0; cpu_w_data = 32'd0;
    @(posedge clk_100M); #1;
    monitorOn = 1'b1;

    // Alternating clock enable with rx_valid held high
    applyReset();
    toggleMode = 1'b1;
    runFrame(2, 32'd0);
    toggleMode = 1'b0;
    rx_valid = 1'b0;

    // Reset after six bytes, then a fresh frame
    applyReset();
    sendWord(32'd2);
    applyStimulus(8'h20);
    applyStimulus(8'h08);
    applyReset();
    frameWords[0] = 32'h1234_5678;
    frameWords[1] = 32'h9ABC_DEF0;
    runFrame(2, 32'd0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      int n = $urandom_range(0, 8);
      logic [31:0] m = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      for (int i = 0; i < 16; i++) frameWords[i] = $urandom;
      applyReset();
      toggleMode = ($urandom_range(0, 2) == 0);
      runFrame(n, m);
      toggleMode = 1'b0;
      rx_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
